// File: rtl/squeeze_stage_pipelined.sv
// ---------------------------------------------------------------------------
// squeeze_stage_pipelined
// Output (squeeze) side of a Keccak-f[1600] sponge. A permuted state is taken
// from the round pipeline and its rate lanes are streamed out as 64-bit beats
// over a valid/ready handshake. When more beats are needed than the rate
// holds, the held state is handed back for another permutation.
//
// Parameters
//   RATE_LANES : 64-bit lanes in the rate (1..25)
//   OUT_LANES  : total 64-bit beats per message (1..65535)
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous reset, active-high
//   state_in     : permuted state, lane L at bits [64L+63:64L]
//   state_valid  : state_in holds a completed permutation
//   state_ready  : block accepts state_in this cycle
//   perm_req     : request another permutation of perm_state
//   perm_state   : held state for the round pipeline
//   out_data     : output lane (0 when out_valid is low)
//   out_valid    : out_data valid
//   out_ready    : downstream accepts the beat
//   out_last     : final beat of the message
//
// Build option
//   SQUEEZE_BYTESWAP_EN : when defined, each lane is byte-reversed on
//                         out_data (lane byte 0 on out_data[63:56]).
// ---------------------------------------------------------------------------
module squeeze_stage_pipelined #(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1599:0] state_in,
    input  logic          state_valid,
    output logic          state_ready,
    output logic          perm_req,
    output logic [1599:0] perm_state,
    output logic [63:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    localparam int IDX_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_PERM = 2'd2;

    localparam logic [15:0]      LAST_CNT = 16'(OUT_LANES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

    logic [1:0]       fsm_q,     fsm_d;
    logic [1599:0]    state_q,   state_d;
    logic [IDX_W-1:0] lane_q,    lane_d;
    logic [15:0]      emitted_q, emitted_d;
    logic [63:0]      data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             last_q,    last_d;
    logic             preq_q,    preq_d;
    logic             xfer_s;

    // Select one lane of a state and format it for the output bus.
    function automatic logic [63:0] pick_lane(input logic [1599:0] s,
                                              input logic [IDX_W-1:0] idx);
        logic [63:0] lane;
        logic [63:0] res;
        lane = s[64*int'(idx) +: 64];
`ifdef SQUEEZE_BYTESWAP_EN
        for (int b = 0; b < 8; b++) begin
            res[8*(7-b) +: 8] = lane[8*b +: 8];
        end
`else
        res = lane;
`endif
        return res;
    endfunction

    assign xfer_s = valid_q & out_ready;

    // Next-state logic for the squeeze controller and its output registers.
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        lane_d    = lane_q;
        emitted_d = emitted_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        preq_d    = preq_q;
        case (fsm_q)
            S_IDLE: begin
                if (state_valid) begin
                    state_d   = state_in;
                    lane_d    = '0;
                    emitted_d = 16'd0;
                    fsm_d     = S_EMIT;
                    valid_d   = 1'b1;
                    data_d    = pick_lane(state_in, '0);
                    last_d    = (LAST_CNT == 16'd0);
                    preq_d    = 1'b0;
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_EMIT: begin
                if (xfer_s) begin
                    emitted_d = emitted_q + 16'd1;
                    // The last-beat exit wins over the rate boundary, so a
                    // digest ending exactly on a boundary never asks for a
                    // further permutation.
                    if (last_q) begin
                        fsm_d   = S_IDLE;
                        valid_d = 1'b0;
                        data_d  = 64'd0;
                        last_d  = 1'b0;
                    end else if (lane_q == LAST_IDX) begin
                        fsm_d   = S_PERM;
                        valid_d = 1'b0;
                        data_d  = 64'd0;
                        last_d  = 1'b0;
                        preq_d  = 1'b1;
                    end else begin
                        lane_d = lane_q + IDX_W'(1);
                        data_d = pick_lane(state_q, lane_q + IDX_W'(1));
                        last_d = ((emitted_q + 16'd1) == LAST_CNT);
                    end
                end else begin
                    fsm_d = S_EMIT;
                end
            end
            S_PERM: begin
                if (state_valid) begin
                    state_d = state_in;
                    lane_d  = '0;
                    fsm_d   = S_EMIT;
                    valid_d = 1'b1;
                    data_d  = pick_lane(state_in, '0);
                    last_d  = (emitted_q == LAST_CNT);
                    preq_d  = 1'b0;
                end else begin
                    fsm_d = S_PERM;
                end
            end
            default: begin
                fsm_d   = S_IDLE;
                valid_d = 1'b0;
                data_d  = 64'd0;
                last_d  = 1'b0;
                preq_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= S_IDLE;
            state_q   <= '0;
            lane_q    <= '0;
            emitted_q <= 16'd0;
            data_q    <= 64'd0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            preq_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            lane_q    <= lane_d;
            emitted_q <= emitted_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            preq_q    <= preq_d;
        end
    end

    // Ready is gated by rst so nothing is accepted during a reset cycle.
    assign state_ready = ~rst & ((fsm_q == S_IDLE) | (fsm_q == S_PERM));
    assign perm_req    = preq_q;
    assign perm_state  = state_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;

endmodule

// File: tb/tb_squeeze_stage_pipelined.sv
module tb_squeeze_stage_pipelined;

    logic          clk = 1'b0;
    logic          rst;
    int            checks = 0;
    int            failures = 0;

    // DUT A: default parameters (RATE_LANES=17, OUT_LANES=4)
    logic [1599:0] a_state_in;
    logic          a_state_valid, a_state_ready, a_perm_req;
    logic [1599:0] a_perm_state;
    logic [63:0]   a_out_data;
    logic          a_out_valid, a_out_ready, a_out_last;

    // DUT B: OUT_LANES=20, crosses one rate boundary
    logic [1599:0] b_state_in;
    logic          b_state_valid, b_state_ready, b_perm_req;
    logic [1599:0] b_perm_state;
    logic [63:0]   b_out_data;
    logic          b_out_valid, b_out_ready, b_out_last;

    always #5 clk = ~clk;

    squeeze_stage_pipelined #(.RATE_LANES(17), .OUT_LANES(4)) dut (
        .clk(clk), .rst(rst), .state_in(a_state_in), .state_valid(a_state_valid),
        .state_ready(a_state_ready), .perm_req(a_perm_req), .perm_state(a_perm_state),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last));

    squeeze_stage_pipelined #(.RATE_LANES(17), .OUT_LANES(20)) dut20 (
        .clk(clk), .rst(rst), .state_in(b_state_in), .state_valid(b_state_valid),
        .state_ready(b_state_ready), .perm_req(b_perm_req), .perm_state(b_perm_state),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last));

    function automatic logic [1599:0] mk_state(input logic [63:0] base);
        logic [1599:0] s;
        for (int l = 0; l < 25; l++) s[64*l +: 64] = base + 64'(l);
        return s;
    endfunction

    // Expected bus value of a lane for the current build.
    function automatic logic [63:0] exp_lane(input logic [63:0] v);
        logic [63:0] r;
`ifdef SQUEEZE_BYTESWAP_EN
        for (int b = 0; b < 8; b++) r[8*(7-b) +: 8] = v[8*b +: 8];
`else
        r = v;
`endif
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [1599:0] s);
        a_state_in    = s;
        a_state_valid = 1'b1;
        cycle();
        a_state_valid = 1'b0;
    endtask

    // Drain the four beats of DUT A with out_ready held high.
    task automatic drain_a(input string tag, input logic [63:0] base);
        logic [65:0] got, exp;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = {a_out_valid, a_out_last, a_out_data};
            exp = {1'b1, (i == 3), exp_lane(base + 64'(i))};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s_beat%0d got=%h expected=%h", tag, i, got, exp);
            end
            cycle();
        end
        got = {a_out_valid, a_out_last, a_out_data};
        checks++;
        if ({a_state_ready, got} !== {1'b1, 66'd0}) begin
            failures++;
            $display("FAIL %s_end ready=%b got=%h expected ready=1 all-zero", tag, a_state_ready, got);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_state_valid = 1'b0; a_out_ready = 1'b0; a_state_in = '0;
        b_state_valid = 1'b0; b_out_ready = 1'b0; b_state_in = '0;
        cycle(); cycle();
        checks++;
        if ({a_state_ready, a_out_valid, a_out_last, a_perm_req, a_out_data} !== 68'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b v=%b l=%b pr=%b d=%h expected all 0",
                     a_state_ready, a_out_valid, a_out_last, a_perm_req, a_out_data);
        end
        checks++;
        if (a_perm_state !== 1600'd0) begin
            failures++;
            $display("FAIL reset_perm_state got nonzero expected 0");
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({a_state_ready, b_state_ready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_ready got=%b%b expected=11", a_state_ready, b_state_ready);
        end
    endtask

    task automatic test_basic();
        a_out_ready = 1'b1;
        load_a(mk_state(64'h1000));
        drain_a("basic", 64'h1000);
    endtask

    task automatic test_backpressure();
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int got_n = 0;
        logic held = 1'b0;
        logic [65:0] held_v, cur, exp;
        logic r;
        a_out_ready = 1'b0;
        load_a(mk_state(64'h1000));
        for (int it = 0; it < 20 && got_n < 4; it++) begin
            cur = {a_out_valid, a_out_last, a_out_data};
            if (held) begin
                checks++;
                if (cur !== held_v) begin
                    failures++;
                    $display("FAIL bp_hold it=%0d got=%h expected=%h", it, cur, held_v);
                end
            end
            r = (it < 7) ? pat[it][0] : 1'b1;
            a_out_ready = r;
            if (a_out_valid && r) begin
                exp = {1'b1, (got_n == 3), exp_lane(64'h1000 + 64'(got_n))};
                checks++;
                if (cur !== exp) begin
                    failures++;
                    $display("FAIL bp_beat%0d got=%h expected=%h", got_n, cur, exp);
                end
                got_n++;
                held = 1'b0;
            end else begin
                held   = a_out_valid;
                held_v = cur;
            end
            cycle();
        end
        checks++;
        if ({got_n, a_out_valid} !== {32'd4, 1'b0}) begin
            failures++;
            $display("FAIL bp_count got=%0d valid=%b expected=4 valid=0", got_n, a_out_valid);
        end
    endtask

    task automatic test_perm();
        logic [65:0] got, exp;
        b_out_ready   = 1'b1;
        b_state_in    = mk_state(64'h1000);
        b_state_valid = 1'b1;
        cycle();
        b_state_valid = 1'b0;
        for (int i = 0; i < 17; i++) begin
            got = {b_out_valid, b_out_last, b_out_data};
            exp = {1'b1, 1'b0, exp_lane(64'h1000 + 64'(i))};
            checks++;
            if (got !== exp || b_perm_req !== 1'b0) begin
                failures++;
                $display("FAIL perm_beat%0d got=%h pr=%b expected=%h pr=0", i, got, b_perm_req, exp);
            end
            cycle();
        end
        for (int w = 0; w < 2; w++) begin
            checks++;
            if ({b_perm_req, b_out_valid, b_state_ready, b_out_data} !== {3'b101, 64'd0} ||
                b_perm_state !== mk_state(64'h1000)) begin
                failures++;
                $display("FAIL perm_wait%0d got pr=%b v=%b rdy=%b d=%h expected pr=1 v=0 rdy=1 d=0",
                         w, b_perm_req, b_out_valid, b_state_ready, b_out_data);
            end
            cycle();
        end
        b_state_in    = mk_state(64'h2000);
        b_state_valid = 1'b1;
        cycle();
        b_state_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = {b_out_valid, b_out_last, b_out_data};
            exp = {1'b1, (i == 2), exp_lane(64'h2000 + 64'(i))};
            checks++;
            if (got !== exp || b_perm_req !== 1'b0) begin
                failures++;
                $display("FAIL perm2_beat%0d got=%h pr=%b expected=%h pr=0", i, got, b_perm_req, exp);
            end
            cycle();
        end
        for (int w = 0; w < 3; w++) begin
            checks++;
            if ({b_perm_req, b_out_valid, b_state_ready} !== 3'b001) begin
                failures++;
                $display("FAIL perm_done%0d got pr=%b v=%b rdy=%b expected pr=0 v=0 rdy=1",
                         w, b_perm_req, b_out_valid, b_state_ready);
            end
            cycle();
        end
    endtask

    task automatic test_midreset();
        a_out_ready = 1'b1;
        load_a(mk_state(64'h1000));
        cycle();
        cycle();
        checks++;
        if (a_out_data !== exp_lane(64'h1002)) begin
            failures++;
            $display("FAIL midrst_pre got=%h expected=%h", a_out_data, exp_lane(64'h1002));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (a_state_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ready_in_rst got=%b expected=0", a_state_ready);
        end
        cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({a_out_valid, a_out_last, a_state_ready, a_out_data} !== {3'b001, 64'd0}) begin
            failures++;
            $display("FAIL midrst_after got v=%b l=%b rdy=%b d=%h expected v=0 l=0 rdy=1 d=0",
                     a_out_valid, a_out_last, a_state_ready, a_out_data);
        end
        load_a(mk_state(64'h3000));
        drain_a("midrst", 64'h3000);
    endtask

    task automatic test_ignore_load();
        a_out_ready = 1'b0;
        load_a(mk_state(64'h4000));
        checks++;
        if (a_state_ready !== 1'b0) begin
            failures++;
            $display("FAIL ignore_ready got=%b expected=0", a_state_ready);
        end
        load_a(mk_state(64'h5000));
        cycle();
        drain_a("ignore", 64'h4000);
    endtask

    task automatic test_byteswap();
        logic [1599:0] s;
        logic [63:0] exp0;
        s = mk_state(64'h6000);
        s[63:0] = 64'h0706050403020100;
`ifdef SQUEEZE_BYTESWAP_EN
        exp0 = 64'h0001020304050607;
`else
        exp0 = 64'h0706050403020100;
`endif
        a_out_ready = 1'b1;
        load_a(s);
        checks++;
        if ({a_out_valid, a_out_data} !== {1'b1, exp0}) begin
            failures++;
            $display("FAIL byteswap_beat0 got v=%b d=%h expected v=1 d=%h", a_out_valid, a_out_data, exp0);
        end
        cycle();
        checks++;
        if ({a_out_valid, a_out_data} !== {1'b1, exp_lane(64'h6001)}) begin
            failures++;
            $display("FAIL byteswap_beat1 got v=%b d=%h expected v=1 d=%h",
                     a_out_valid, a_out_data, exp_lane(64'h6001));
        end
        cycle(); cycle(); cycle();
        checks++;
        if ({a_out_valid, a_state_ready} !== 2'b01) begin
            failures++;
            $display("FAIL byteswap_end got v=%b rdy=%b expected v=0 rdy=1", a_out_valid, a_state_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_perm();
        test_midreset();
        test_ignore_load();
        test_byteswap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
